cache_data_array: RTL and testbench
===================================

# cache_data_array

Parametrised N-way data store for the L1 cache, successor to the fixed 2-way, 8-line, 8-word data table. Holds `WAYS × LINES × WORDS` words and serves four clients:
- a 1-cycle registered CPU read port;
- a byte-enabled CPU write port;
- a burst line-fill engine fed by the memory side (valid/ready);
- a burst eviction engine that streams a victim line out to memory (valid/ready).

It sits between the cache control/tag logic, which decides way, line and hit, and the memory bus interface.

## Interface
Parameters:
- `WAYS`, 2: associativity; ≥1.
- `LINES`, 8: sets per way; power of two.
- `WORDS`, 8: words per line; power of two.
- `WIDTH`, 32: word width; multiple of 8.
- Derived: `WAYW = max(1, clog2(WAYS))`, `LINEW = clog2(LINES)`, `WORDW = clog2(WORDS)`.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: reset; asynchronous, active-low.
- `rdEn` in 1: CPU read request.
- `rdWay`, `rdLine`, `rdWord` in WAYW/LINEW/WORDW: read address.
- `rdData` out WIDTH: registered read data.
- `wrEn` in 1: CPU write request.
- `wrWay`, `wrLine`, `wrWord` in WAYW/LINEW/WORDW: write address.
- `wrBe` in WIDTH/8: byte enables.
- `wrData` in WIDTH: write data.
- `fillStart` in 1: begin line fill.
- `fillWay`, `fillLine` in WAYW/LINEW: fill target, sampled at start.
- `fillValid` in 1, `fillData` in WIDTH: memory beat.
- `fillReady` out 1: array accepts a fill beat.
- `fillDone` out 1: 1-cycle pulse after the last fill beat.
- `evictStart` in 1: begin line eviction.
- `evictWay`, `evictLine` in WAYW/LINEW: victim, sampled at start.
- `evictValid` out 1, `evictData` out WIDTH: outgoing beat.
- `evictReady` in 1: memory accepts a beat.
- `evictDone` out 1: 1-cycle pulse after the last evict beat.
- `busy` out 1: high whenever the state is not IDLE.

## Operation
- States: IDLE, FILL, EVICT. A `WORDW`-bit beat counter, plus target way/line registers latched on start.
- IDLE:
  - `evictStart` → EVICT.
  - else `fillStart` → FILL.
  - Both asserted in the same cycle → EVICT; `fillStart` is dropped and control must reissue it.
  - Starts are ignored outside IDLE.
- FILL:
  - `fillReady=1`.
  - Each cycle with `fillValid&&fillReady`, `fillData` is written to word `cnt` of the latched way/line and `cnt` increments.
  - Beat `WORDS-1` → IDLE, `fillDone=1` in the following cycle.
- EVICT:
  - `evictValid=1`; `evictData` = word `cnt` of the latched way/line, combinational from the array.
  - `cnt` increments on `evictValid&&evictReady`.
  - Data holds stable while stalled.
  - Last beat → IDLE, `evictDone=1` in the following cycle.
- CPU write:
  - Honoured only when `busy=0`; ignored while busy. Control must not issue writes then.
  - Byte `i` (bits `8i+7:8i`) is written only if `wrBe[i]`.
- CPU read: honoured in every state. With `rdEn=0`, `rdData` holds its last value.
- Read and write to the same word in the same cycle: `rdData` returns the pre-write value.
- Way index ≥ `WAYS` (non-power-of-two `WAYS`): writes, fills and starts to it are ignored; reads return 0.
- Counter wraps to 0 on completion; no partial-line transfers.

## Timing
- Reset (`rst=0`, asynchronous), regardless of state:
  - state IDLE, `cnt=0`, whole array cleared to 0;
  - `rdData=0`, `fillReady=0`, `fillDone=0`, `evictValid=0`, `evictData=0`, `busy=0`, `evictDone=0`.
- Reset mid-burst aborts the burst with no done pulse.
- Read latency 1: `rdEn` sampled at edge N, `rdData` valid after edge N (cycle N+1).
- Write latency 1: data is visible to a read issued the cycle after `wrEn`.
- `fillStart` at edge N:
  - `busy` and `fillReady` high from cycle N+1.
  - Minimum burst of `WORDS` cycles when `fillValid` is held high.
  - `fillDone` at cycle N+1+`WORDS`.
- `evictStart` at edge N:
  - `evictValid` with word 0 in cycle N+1.
  - With `evictReady` held high, `evictDone` at cycle N+1+`WORDS`.
- A new start is accepted in the cycle `fillDone`/`evictDone` is high, since the state is already IDLE.

## Test plan
- **Reset and clear:** drive `rst=0` mid-operation, release, read way1 line3 word5 → all outputs 0 during reset; `rdData=0x00000000`.
- **Byte enables:**
  - write way1 line3 word5 `0xDEADBEEF`, `wrBe=4'b1111`;
  - then write `0x00001200`, `wrBe=4'b0010`;
  - read the word → `rdData=0xDEAD12EF` exactly one cycle after `rdEn`.
- **Fill with gaps:**
  - fill way0 line7 with beats `0x100`..`0x107`, `fillValid` low every other cycle;
  - → `fillDone` one cycle after the 8th accepted beat;
  - reads of words 0..7 return `0x100`..`0x107`;
  - way1 line7 is unchanged.
- **Evict with backpressure:**
  - evict the filled line with `evictReady` toggling;
  - → 8 beats `0x100`..`0x107` in order;
  - `evictData` stable while `evictReady=0`;
  - `evictDone` pulses once.
- **Collisions:**
  - `fillStart` and `evictStart` in the same cycle → EVICT is entered and the fill is dropped;
  - `wrEn` during EVICT → array unchanged;
  - `rdEn` during FILL → returns the correct data.
- **Abort:** assert `rst` after 3 fill beats → `busy=0`, `fillReady=0`, no `fillDone`, filled words read 0.

Source files
------------

// File: rtl/cache_data_array.sv
// rtl/cache_data_array.sv - parametrised N-way L1 cache data store with fill and evict burst engines
//
// Ports:
//   clk, rst                      clock; asynchronous active-low reset (clears whole array)
//   rdEn/rdWay/rdLine/rdWord      CPU read request, rdData registered one cycle later
//   wrEn/wrWay/wrLine/wrWord      CPU write request (idle only), wrBe byte enables, wrData
//   fillStart/fillWay/fillLine    start a line fill; fillValid/fillData beats, fillReady, fillDone
//   evictStart/evictWay/evictLine start a line eviction; evictValid/evictData beats, evictReady, evictDone
//   busy                          high while a fill or eviction burst is in progress
module cache_data_array #(
    parameter int  WAYS  = 2,
    parameter int  LINES = 8,
    parameter int  WORDS = 8,
    parameter int  WIDTH = 32,
    localparam int WAYW  = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int LINEW = $clog2(LINES),
    localparam int WORDW = $clog2(WORDS),
    localparam int NBE   = WIDTH / 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdEn,
    input  logic [WAYW-1:0]  rdWay,
    input  logic [LINEW-1:0] rdLine,
    input  logic [WORDW-1:0] rdWord,
    output logic [WIDTH-1:0] rdData,
    input  logic             wrEn,
    input  logic [WAYW-1:0]  wrWay,
    input  logic [LINEW-1:0] wrLine,
    input  logic [WORDW-1:0] wrWord,
    input  logic [NBE-1:0]   wrBe,
    input  logic [WIDTH-1:0] wrData,
    input  logic             fillStart,
    input  logic [WAYW-1:0]  fillWay,
    input  logic [LINEW-1:0] fillLine,
    input  logic             fillValid,
    input  logic [WIDTH-1:0] fillData,
    output logic             fillReady,
    output logic             fillDone,
    input  logic             evictStart,
    input  logic [WAYW-1:0]  evictWay,
    input  logic [LINEW-1:0] evictLine,
    output logic             evictValid,
    output logic [WIDTH-1:0] evictData,
    input  logic             evictReady,
    output logic             evictDone,
    output logic             busy
);

    localparam int AW    = WAYW + LINEW + WORDW;
    localparam int DEPTH = WAYS * LINES * WORDS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FILL,
        S_EVICT
    } state_t;

    state_t           state_q, state_d;
    logic [WORDW-1:0] cnt_q, cnt_d;
    logic [WAYW-1:0]  way_q, way_d;
    logic [LINEW-1:0] line_q, line_d;
    logic             fill_done_q, fill_done_d;
    logic             evict_done_q, evict_done_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic [WIDTH-1:0] mem_q [DEPTH];

    logic             fill_we;
    logic             cpu_we;
    logic             last_beat;
    logic [AW-1:0]    rd_idx;
    logic [AW-1:0]    wr_idx;
    logic [AW-1:0]    xfer_idx;

    // Way indices beyond WAYS only exist when WAYS is not a power of two;
    // anything addressing them is dropped and reads return zero.
    function automatic logic way_ok(input logic [WAYW-1:0] w);
        return int'(w) < WAYS;
    endfunction

    // LINES and WORDS are powers of two, so the flat index is a plain concatenation.
    assign rd_idx    = {rdWay, rdLine, rdWord};
    assign wr_idx    = {wrWay, wrLine, wrWord};
    assign xfer_idx  = {way_q, line_q, cnt_q};
    assign last_beat = (cnt_q == WORDW'(WORDS - 1));
    assign cpu_we    = wrEn && (state_q == S_IDLE) && way_ok(wrWay);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        way_d        = way_q;
        line_d       = line_q;
        fill_done_d  = 1'b0;
        evict_done_d = 1'b0;
        fill_we      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Eviction wins a simultaneous start; the fill request is dropped.
                if (evictStart && way_ok(evictWay)) begin
                    state_d = S_EVICT;
                    way_d   = evictWay;
                    line_d  = evictLine;
                    cnt_d   = '0;
                end else if (fillStart && way_ok(fillWay)) begin
                    state_d = S_FILL;
                    way_d   = fillWay;
                    line_d  = fillLine;
                    cnt_d   = '0;
                end
            end
            S_FILL: begin
                if (fillValid) begin
                    fill_we = 1'b1;
                    cnt_d   = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d     = S_IDLE;
                        fill_done_d = 1'b1;
                    end
                end
            end
            S_EVICT: begin
                if (evictReady) begin
                    cnt_d = cnt_q + 1'b1;
                    if (last_beat) begin
                        state_d      = S_IDLE;
                        evict_done_d = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Reads sample the array before this edge's write lands, so a same-cycle
    // read/write collision returns the old word.
    always_comb begin
        rd_data_d = rd_data_q;
        if (rdEn) begin
            rd_data_d = way_ok(rdWay) ? mem_q[rd_idx] : '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            way_q        <= '0;
            line_q       <= '0;
            fill_done_q  <= 1'b0;
            evict_done_q <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            way_q        <= way_d;
            line_q       <= line_d;
            fill_done_q  <= fill_done_d;
            evict_done_q <= evict_done_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Fill and CPU writes are mutually exclusive: CPU writes only land in IDLE.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (fill_we) begin
            mem_q[xfer_idx] <= fillData;
        end else if (cpu_we) begin
            for (int b = 0; b < NBE; b++) begin
                if (wrBe[b]) begin
                    mem_q[wr_idx][8*b +: 8] <= wrData[8*b +: 8];
                end
            end
        end
    end

    assign rdData     = rd_data_q;
    assign fillReady  = (state_q == S_FILL);
    assign fillDone   = fill_done_q;
    assign evictValid = (state_q == S_EVICT);
    // Straight from the array: the latched address only moves on a handshake,
    // so the beat holds steady under backpressure.
    assign evictData  = evictValid ? mem_q[xfer_idx] : '0;
    assign evictDone  = evict_done_q;
    assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_cache_data_array.sv
// tb/tb_cache_data_array.sv - scoreboard testbench for cache_data_array
module tb_cache_data_array;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdEn = 1'b0;
    logic [0:0]  rdWay = '0;
    logic [2:0]  rdLine = '0;
    logic [2:0]  rdWord = '0;
    logic [31:0] rdData;
    logic        wrEn = 1'b0;
    logic [0:0]  wrWay = '0;
    logic [2:0]  wrLine = '0;
    logic [2:0]  wrWord = '0;
    logic [3:0]  wrBe = '0;
    logic [31:0] wrData = '0;
    logic        fillStart = 1'b0;
    logic [0:0]  fillWay = '0;
    logic [2:0]  fillLine = '0;
    logic        fillValid = 1'b0;
    logic [31:0] fillData = '0;
    logic        fillReady;
    logic        fillDone;
    logic        evictStart = 1'b0;
    logic [0:0]  evictWay = '0;
    logic [2:0]  evictLine = '0;
    logic        evictValid;
    logic [31:0] evictData;
    logic        evictReady = 1'b0;
    logic        evictDone;
    logic        busy;

    cache_data_array #(.WAYS(2), .LINES(8), .WORDS(8), .WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .rdEn(rdEn), .rdWay(rdWay), .rdLine(rdLine), .rdWord(rdWord), .rdData(rdData),
        .wrEn(wrEn), .wrWay(wrWay), .wrLine(wrLine), .wrWord(wrWord), .wrBe(wrBe), .wrData(wrData),
        .fillStart(fillStart), .fillWay(fillWay), .fillLine(fillLine),
        .fillValid(fillValid), .fillData(fillData), .fillReady(fillReady), .fillDone(fillDone),
        .evictStart(evictStart), .evictWay(evictWay), .evictLine(evictLine),
        .evictValid(evictValid), .evictData(evictData), .evictReady(evictReady), .evictDone(evictDone),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: word store plus the burst in progress (0 idle, 1 fill, 2 evict).
    logic [31:0] mdl [2][8][8];
    int          mode_nx = 0, mode_cur = 0;
    int          m_beat = 0;
    logic [0:0]  m_way = '0;
    logic [2:0]  m_line = '0;
    bit          fd_nx = 0, fd_cur = 0, ed_nx = 0, ed_cur = 0;
    bit          rd_seen = 0;
    logic [31:0] rd_q [$];
    logic [31:0] ev_q [$];
    int          vectors = 0;
    int          miscompares = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_cur <= 0;
            fd_cur   <= 0;
            ed_cur   <= 0;
            rd_seen  <= 0;
        end else begin
            mode_cur <= mode_nx;
            fd_cur   <= fd_nx;
            ed_cur   <= ed_nx;
            rd_seen  <= rdEn;
        end
    end

    // Monitor: checks outputs away from the active edge against the scoreboard.
    always @(negedge clk) begin
        logic [31:0] e;
        if (!rst) begin
            chk("rst_busy", 32'(busy), 32'd0);
            chk("rst_fillReady", 32'(fillReady), 32'd0);
            chk("rst_fillDone", 32'(fillDone), 32'd0);
            chk("rst_evictValid", 32'(evictValid), 32'd0);
            chk("rst_evictDone", 32'(evictDone), 32'd0);
            chk("rst_evictData", evictData, 32'd0);
            chk("rst_rdData", rdData, 32'd0);
        end else begin
            chk("busy", 32'(busy), 32'(mode_cur != 0));
            chk("fillReady", 32'(fillReady), 32'(mode_cur == 1));
            chk("evictValid", 32'(evictValid), 32'(mode_cur == 2));
            chk("fillDone", 32'(fillDone), 32'(fd_cur));
            chk("evictDone", 32'(evictDone), 32'(ed_cur));
            if (rd_seen) begin
                if (rd_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL rd_q: read data %h with no expected entry", rdData);
                end else begin
                    e = rd_q.pop_front();
                    chk("rdData", rdData, e);
                end
            end
            if (evictValid) begin
                if (ev_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL ev_q: evict beat %h with no expected entry", evictData);
                end else begin
                    chk("evictData", evictData, ev_q[0]);
                    if (evictReady) void'(ev_q.pop_front());
                end
            end
        end
    end

    // Applies this cycle's inputs to the model (read first, so it sees pre-write data).
    task automatic commit();
        fd_nx   = 0;
        ed_nx   = 0;
        mode_nx = mode_cur;
        if (rdEn) rd_q.push_back(mdl[rdWay][rdLine][rdWord]);
        case (mode_cur)
            0: begin
                if (wrEn) begin
                    for (int b = 0; b < 4; b++)
                        if (wrBe[b]) mdl[wrWay][wrLine][wrWord][8*b +: 8] = wrData[8*b +: 8];
                end
                if (evictStart) begin
                    mode_nx = 2; m_way = evictWay; m_line = evictLine; m_beat = 0;
                    for (int w = 0; w < 8; w++) ev_q.push_back(mdl[evictWay][evictLine][w]);
                end else if (fillStart) begin
                    mode_nx = 1; m_way = fillWay; m_line = fillLine; m_beat = 0;
                end
            end
            1: if (fillValid) begin
                mdl[m_way][m_line][m_beat] = fillData;
                m_beat++;
                if (m_beat == 8) begin mode_nx = 0; fd_nx = 1; end
            end
            2: if (evictReady) begin
                m_beat++;
                if (m_beat == 8) begin mode_nx = 0; ed_nx = 1; end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        commit();
        @(posedge clk);
        #1;
        rdEn = 0; wrEn = 0; wrBe = '0; fillStart = 0; evictStart = 0;
        fillValid = 0; evictReady = 0;
    endtask

    task automatic do_reset();
        rdEn = 0; wrEn = 0; fillStart = 0; evictStart = 0; fillValid = 0; evictReady = 0;
        rst = 0;
        for (int a = 0; a < 2; a++)
            for (int l = 0; l < 8; l++)
                for (int w = 0; w < 8; w++) mdl[a][l][w] = '0;
        rd_q.delete();
        ev_q.delete();
        mode_nx = 0; fd_nx = 0; ed_nx = 0; m_beat = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1;
    endtask

    task automatic rd(input int way, input int line, input int word);
        rdEn = 1; rdWay = 1'(way); rdLine = 3'(line); rdWord = 3'(word);
        tick();
    endtask

    task automatic wr(input int way, input int line, input int word,
                      input logic [31:0] data, input logic [3:0] be);
        wrEn = 1; wrWay = 1'(way); wrLine = 3'(line); wrWord = 3'(word);
        wrData = data; wrBe = be;
        tick();
    endtask

    task automatic wait_idle(input string name, input bit gaps, input logic [31:0] base);
        int n = 0;
        while (mode_cur != 0 && n < 100) begin
            fillValid  = gaps ? bit'(n % 2) : 1'b1;
            fillData   = base + 32'(m_beat);
            evictReady = gaps ? bit'(n % 2) : 1'b1;
            if (n == 3 && mode_cur == 1) begin
                rdEn = 1; rdWay = m_way; rdLine = m_line; rdWord = 3'd0;
            end
            tick();
            n++;
        end
        if (mode_cur != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: burst did not complete within 100 cycles", name);
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        rst = 1;

        // Reset in the middle of a fill, then read the cleared array.
        fillStart = 1; fillWay = 1; fillLine = 3; tick();
        fillValid = 1; fillData = 32'h55; tick();
        do_reset();
        rd(1, 3, 5);
        tick();

        // Byte enables: expect DEAD12EF.
        wr(1, 3, 5, 32'hDEADBEEF, 4'b1111);
        wr(1, 3, 5, 32'h00001200, 4'b0010);
        rd(1, 3, 5);
        tick();

        // Marker in way1 line7 to prove the fill of way0 line7 leaves it alone.
        wr(1, 7, 2, 32'hCAFEF00D, 4'b1111);
        fillStart = 1; fillWay = 0; fillLine = 7; tick();
        wait_idle("fill_gaps", 1, 32'h100);
        tick();
        for (int w = 0; w < 8; w++) rd(0, 7, w);
        for (int w = 0; w < 8; w++) rd(1, 7, w);

        // Evict with toggling backpressure.
        evictStart = 1; evictWay = 0; evictLine = 7; tick();
        wait_idle("evict_bp", 1, 32'h0);
        tick();

        // Simultaneous starts: evict wins; CPU write during evict is ignored.
        fillStart = 1; fillWay = 1; fillLine = 0;
        evictStart = 1; evictWay = 1; evictLine = 3; tick();
        wrEn = 1; wrWay = 1; wrLine = 3; wrWord = 5; wrData = 32'h12345678; wrBe = 4'hF;
        evictReady = 1; tick();
        wait_idle("collide", 0, 32'h0);
        rd(1, 3, 5);
        rd(1, 0, 0);
        tick();

        // Abort a fill after three beats.
        fillStart = 1; fillWay = 0; fillLine = 2; tick();
        for (int i = 0; i < 3; i++) begin
            fillValid = 1; fillData = 32'hA0 + 32'(i); tick();
        end
        do_reset();
        for (int w = 0; w < 3; w++) rd(0, 2, w);
        tick();

        // Randomised traffic against the model.
        for (int it = 0; it < 600; it++) begin
            int r;
            rdEn = 1'($urandom % 2);
            rdWay = 1'($urandom); rdLine = 3'($urandom); rdWord = 3'($urandom);
            wrEn = ($urandom % 3) == 0;
            wrWay = 1'($urandom); wrLine = 3'($urandom); wrWord = 3'($urandom);
            wrData = $urandom; wrBe = 4'($urandom);
            r = (mode_cur == 0) ? int'($urandom % 8) : int'($urandom % 12);
            fillStart  = (r == 0) || (r == 2);
            evictStart = (r == 1) || (r == 2);
            fillWay = 1'($urandom); fillLine = 3'($urandom);
            evictWay = 1'($urandom); evictLine = 3'($urandom);
            fillValid = 1'($urandom % 2); fillData = $urandom;
            evictReady = 1'($urandom % 2);
            tick();
            if (it == 300) do_reset();
        end
        wait_idle("drain", 0, 32'h900);
        repeat (3) tick();

        if (rd_q.size() != 0 || ev_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL leftover: %0d reads, %0d evict beats never observed", rd_q.size(), ev_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
